// File: rtl/niossoc_ledr.sv
// niossoc_ledr: Avalon-MM LED output port with per-bit blink mask.
// DATA holds the static LED pattern. Bits set in BLINK are gated by a square wave
// whose half-period is PERIOD+1 clocks. Reads return data one cycle after the address.
module niossoc_ledr #(
  parameter int unsigned WIDTH        = 18,
  parameter logic [23:0] RESET_PERIOD = 24'd12499999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned CNT_W = 24;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK    = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_blink;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_counter;
  logic             r_phase;

  logic             w_wr;
  logic             w_period_wr;
  logic             w_tc;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_data_nxt;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign w_wr        = chipselect && !write_n;
  assign w_period_wr = w_wr && (address == ADDR_PERIOD);
  assign w_tc        = (r_counter == r_period);
  assign w_wdata     = writedata[WIDTH-1:0];

  // Upper write-data bits have no destination in any register.
  assign w_unused_wdata = ^writedata[31:CNT_W];

  // Next DATA value: direct load, bit-set or bit-clear; anything else holds.
  always_comb begin
    w_data_nxt = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA:     w_data_nxt = w_wdata;
        ADDR_OUTSET:   w_data_nxt = r_data | w_wdata;
        ADDR_OUTCLEAR: w_data_nxt = r_data & ~w_wdata;
        default:       w_data_nxt = r_data;
      endcase
    end
  end

  // Read mux from current (pre-write) register state; write-only and reserved read 0.
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      ADDR_DATA:   w_rd_mux = 32'(r_data);
      ADDR_BLINK:  w_rd_mux = 32'(r_blink);
      ADDR_PERIOD: w_rd_mux = 32'(r_period);
      ADDR_STATUS: w_rd_mux = 32'({r_counter, r_phase});
      default:     w_rd_mux = 32'd0;
    endcase
  end

  // Control registers: DATA, BLINK, PERIOD.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_blink  <= '0;
      r_period <= RESET_PERIOD;
    end else begin
      r_data <= w_data_nxt;
      if (w_wr && (address == ADDR_BLINK)) begin
        r_blink <= w_wdata;
      end
      if (w_period_wr) begin
        r_period <= writedata[CNT_W-1:0];
      end
    end
  end

  // Blink timebase: a PERIOD write restarts it, which wins over a terminal count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_counter <= '0;
      r_phase   <= 1'b0;
    end else if (w_period_wr) begin
      r_counter <= '0;
      r_phase   <= 1'b0;
    end else if (w_tc) begin
      r_counter <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_counter <= r_counter + CNT_W'(1);
    end
  end

  // Registered read data, captured every cycle regardless of chipselect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  // LED drive: blinking bits are blanked while phase is high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_port <= '0;
    end else begin
      out_port <= r_data & ~(r_blink & {WIDTH{r_phase}});
    end
  end

endmodule
